// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - shared SECDED (10,5) constants, status codes and helpers
package secded_pkg;
   localparam int CW_W   = 10;
   localparam int DATA_W = 5;
   localparam int SYN_W  = 4;

   localparam logic [SYN_W-1:0] ERR_POS_PARITY = 4'd10;

   typedef enum logic [1:0] {
      ST_CLEAN  = 2'd0,
      ST_CORR   = 2'd1,
      ST_UNCORR = 2'd2
   } status_t;

   // syndrome bit k covers every Hamming position whose index has bit k set
   function automatic logic [SYN_W-1:0] syndrome(input logic [CW_W-1:0] cw);
      syndrome = {cw[7] ^ cw[8],
                  cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                  cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                  cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ cw[8]};
   endfunction

   function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
      extract = {cw[8], cw[6], cw[5], cw[4], cw[2]};
   endfunction
endpackage

// File: rtl/secded_syndrome.sv
// rtl/secded_syndrome.sv - combinational syndrome and overall-parity generator
module secded_syndrome
   import secded_pkg::*;
(
   input  logic [CW_W-1:0]  codeword,
   output logic [SYN_W-1:0] syn,
   output logic             par
);
   assign syn = syndrome(codeword);
   assign par = ^codeword;
endmodule

// File: rtl/secded_stream_decoder.sv
// rtl/secded_stream_decoder.sv - 2-stage stallable SECDED decoder with saturating stats
module secded_stream_decoder
   import secded_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_codeword,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_status,
   output logic [SYN_W-1:0]  out_err_pos,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  corrected_cnt,
   output logic [CNT_W-1:0]  uncorrectable_cnt
);
   logic              stall;
   logic [SYN_W-1:0]  in_syn;
   logic              in_par;

   logic              s1_valid;
   logic [CW_W-1:0]   s1_cw;
   logic [SYN_W-1:0]  s1_syn;
   logic              s1_par;

   logic [CW_W-1:0]   fix_cw;
   status_t           fix_status;
   logic [SYN_W-1:0]  fix_pos;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   secded_syndrome u_syndrome (
      .codeword (in_codeword),
      .syn      (in_syn),
      .par      (in_par)
   );

   always_ff @(posedge clk) begin
      if (!stall && in_valid) begin
         s1_cw  <= in_codeword;
         s1_syn <= in_syn;
         s1_par <= in_par;
      end
   end

   // odd overall parity means an odd number of flips; only a 1..9 syndrome names a real bit
   always_comb begin
      fix_cw     = s1_cw;
      fix_status = ST_CLEAN;
      fix_pos    = '0;
      if (s1_par) begin
         if (s1_syn == '0) begin
            fix_status = ST_CORR;
            fix_pos    = ERR_POS_PARITY;
         end else if (s1_syn <= 4'd9) begin
            fix_cw     = s1_cw ^ (CW_W'(1) << (s1_syn - 4'd1));
            fix_status = ST_CORR;
            fix_pos    = s1_syn;
         end else begin
            fix_status = ST_UNCORR;
            fix_pos    = s1_syn;
         end
      end else if (s1_syn != '0) begin
         fix_status = ST_UNCORR;
         fix_pos    = s1_syn;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_status  <= ST_CLEAN;
         out_err_pos <= '0;
      end else if (!stall) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data    <= extract(fix_cw);
            out_status  <= fix_status;
            out_err_pos <= fix_pos;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         corrected_cnt     <= '0;
         uncorrectable_cnt <= '0;
      end else if (out_valid && out_ready) begin
         if (out_status == ST_CORR && corrected_cnt != '1)
            corrected_cnt <= corrected_cnt + CNT_W'(1);
         if (out_status == ST_UNCORR && uncorrectable_cnt != '1)
            uncorrectable_cnt <= uncorrectable_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_secded_stream_decoder.sv
// tb/tb_secded_stream_decoder.sv - scoreboard bench for secded_stream_decoder
`timescale 1ns/1ps
module tb_secded_stream_decoder;
   typedef struct {
      logic [4:0] data;
      logic [1:0] status;
      logic [3:0] pos;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [9:0] in_codeword = '0;
   logic       out_ready = 1'b0;
   logic       clr_cnt = 1'b0;

   logic       in_ready, out_valid;
   logic [4:0] out_data;
   logic [1:0] out_status;
   logic [3:0] out_err_pos;
   logic [7:0] corrected_cnt, uncorrectable_cnt;

   logic       s_in_ready, s_out_valid;
   logic [4:0] s_out_data;
   logic [1:0] s_out_status;
   logic [3:0] s_out_err_pos;
   logic [1:0] s_corrected_cnt, s_uncorrectable_cnt;

   bit rand_mode = 0;
   bit ready_force = 0;
   bit clr_force = 0;

   int n_checks = 0;
   int n_pass = 0;
   int n_out = 0;
   int m_corr = 0, m_unc = 0, ms_corr = 0, ms_unc = 0;
   exp_t exp_q[$];

   secded_stream_decoder #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_codeword(in_codeword), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_status(out_status), .out_err_pos(out_err_pos),
      .clr_cnt(clr_cnt), .corrected_cnt(corrected_cnt),
      .uncorrectable_cnt(uncorrectable_cnt)
   );

   secded_stream_decoder #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_codeword(in_codeword), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .out_status(s_out_status), .out_err_pos(s_out_err_pos),
      .clr_cnt(clr_cnt), .corrected_cnt(s_corrected_cnt),
      .uncorrectable_cnt(s_uncorrectable_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input string detail);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   // reference: data sits at non-power-of-two positions; parity p covers positions q with q&p
   function automatic logic [9:0] encode(input logic [4:0] d);
      logic [9:0] cw = '0;
      int k = 0;
      for (int pos = 1; pos <= 9; pos++)
         if (!is_pow2(pos)) begin cw[pos-1] = d[k]; k++; end
      for (int pos = 1; pos <= 9; pos++)
         if (is_pow2(pos))
            for (int q = 1; q <= 9; q++)
               if ((q & pos) != 0 && q != pos) cw[pos-1] = cw[pos-1] ^ cw[q-1];
      cw[9] = ^cw[8:0];
      return cw;
   endfunction

   function automatic exp_t ref_decode(input logic [9:0] cw);
      exp_t e;
      int syn = 0;
      int par = 0;
      int k = 0;
      logic [9:0] fixed = cw;
      for (int i = 0; i < 10; i++)
         if (cw[i]) begin
            par ^= 1;
            if (i < 9) syn ^= (i + 1);
         end
      if (par == 0 && syn == 0) begin e.status = 2'd0; e.pos = 4'd0; end
      else if (par == 1 && syn == 0) begin e.status = 2'd1; e.pos = 4'd10; end
      else if (par == 1 && syn <= 9) begin
         fixed[syn-1] = ~fixed[syn-1];
         e.status = 2'd1; e.pos = 4'(syn);
      end else begin e.status = 2'd2; e.pos = 4'(syn); end
      e.data = '0;
      for (int pos = 1; pos <= 9; pos++)
         if (!is_pow2(pos)) begin e.data[k] = fixed[pos-1]; k++; end
      return e;
   endfunction

   function automatic logic [9:0] rand_word(input int nflip);
      logic [9:0] mask = '0;
      logic [4:0] d = 5'($urandom);
      while ($countones(mask) < nflip) mask[$urandom_range(0, 9)] = 1'b1;
      return encode(d) ^ mask;
   endfunction

   // called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_exp(input logic [9:0] cw, input exp_t e);
      int waited = 0;
      bit ok = 1;
      in_valid = 1'b1;
      in_codeword = cw;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) begin ok = 0; break; end
      end
      check(ok, "accept_timeout", $sformatf("word %h not accepted in %0d cycles", cw, waited));
      if (ok) exp_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [9:0] cw);
      send_exp(cw, ref_decode(cw));
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 1000) begin @(posedge clk); t++; end
      check(exp_q.size() == 0, "drain", $sformatf("%0d words still pending, want 0", exp_q.size()));
      @(posedge clk); #1;
   endtask

   task automatic wait_out_valid(input string name);
      int t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 50);
      check(out_valid, name, $sformatf("out_valid=%0b after %0d cycles, want 1", out_valid, t));
   endtask

   initial begin : ready_driver
      forever begin
         @(posedge clk); #2;
         if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 49) == 0);
         end else begin
            out_ready = ready_force;
            clr_cnt   = clr_force;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      bit prev_stall = 0;
      logic [4:0] pd = '0;
      logic [1:0] ps = '0;
      logic [3:0] pp = '0;
      logic [1:0] st;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            m_corr = 0; m_unc = 0; ms_corr = 0; ms_unc = 0;
            prev_stall = 0;
         end else begin
            check(corrected_cnt == 8'(m_corr), "corrected_cnt",
                  $sformatf("got %0d want %0d", corrected_cnt, m_corr));
            check(uncorrectable_cnt == 8'(m_unc), "uncorrectable_cnt",
                  $sformatf("got %0d want %0d", uncorrectable_cnt, m_unc));
            check(s_corrected_cnt == 2'(ms_corr), "small_corrected_cnt",
                  $sformatf("got %0d want %0d", s_corrected_cnt, ms_corr));
            check(s_uncorrectable_cnt == 2'(ms_unc), "small_uncorrectable_cnt",
                  $sformatf("got %0d want %0d", s_uncorrectable_cnt, ms_unc));
            check(in_ready == !(out_valid && !out_ready), "in_ready",
                  $sformatf("got %0b with out_valid=%0b out_ready=%0b", in_ready, out_valid, out_ready));
            if (prev_stall)
               check(out_valid && out_data == pd && out_status == ps && out_err_pos == pp, "hold",
                     $sformatf("got v=%0b %h/%0d/%0d want v=1 %h/%0d/%0d",
                               out_valid, out_data, out_status, out_err_pos, pd, ps, pp));
            st = 2'd0;
            if (out_valid && out_ready) begin
               n_out++;
               st = out_status;
               check(exp_q.size() != 0, "unexpected_out", $sformatf("got word %h with empty scoreboard", out_data));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  st = e.status;
                  check(out_data == e.data && out_status == e.status && out_err_pos == e.pos, "word",
                        $sformatf("got data=%b st=%0d pos=%0d want data=%b st=%0d pos=%0d",
                                  out_data, out_status, out_err_pos, e.data, e.status, e.pos));
               end
            end
            if (clr_cnt) begin
               m_corr = 0; m_unc = 0; ms_corr = 0; ms_unc = 0;
            end else if (out_valid && out_ready) begin
               if (st == 2'd1) begin
                  m_corr  = (m_corr  == 255) ? 255 : m_corr + 1;
                  ms_corr = (ms_corr == 3)   ? 3   : ms_corr + 1;
               end
               if (st == 2'd2) begin
                  m_unc  = (m_unc  == 255) ? 255 : m_unc + 1;
                  ms_unc = (ms_unc == 3)   ? 3   : ms_unc + 1;
               end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; ps = out_status; pp = out_err_pos;
         end
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check(out_valid == 0, "reset_out_valid", $sformatf("got %0b want 0", out_valid));
      check(in_ready == 1, "reset_in_ready", $sformatf("got %0b want 1", in_ready));
      check(out_data == 0 && out_status == 0 && out_err_pos == 0, "reset_outputs",
            $sformatf("got %h/%0d/%0d want 0/0/0", out_data, out_status, out_err_pos));
      check(corrected_cnt == 0 && uncorrectable_cnt == 0, "reset_counters",
            $sformatf("got %0d/%0d want 0/0", corrected_cnt, uncorrectable_cnt));

      // directed vectors from the data word 5'b10110
      ready_force = 1;
      send_exp(10'h3B2, '{data: 5'b10110, status: 2'd0, pos: 4'd0});
      send_exp(10'h392, '{data: 5'b10110, status: 2'd1, pos: 4'd6});
      send_exp(10'h1B2, '{data: 5'b10110, status: 2'd1, pos: 4'd10});
      send_exp(10'h393, '{data: 5'b10010, status: 2'd2, pos: 4'd7});
      send_exp(10'h331, '{data: 5'b10110, status: 2'd2, pos: 4'd11});
      drain();
      check(corrected_cnt == 2 && uncorrectable_cnt == 2, "directed_counters",
            $sformatf("got %0d/%0d want 2/2", corrected_cnt, uncorrectable_cnt));

      // backpressure: out_ready low while four words stream in
      ready_force = 0;
      base = n_out;
      fork
         begin
            for (int i = 0; i < 4; i++) send(rand_word(i));
         end
         begin
            wait_out_valid("bp_fill");
            check(in_ready == 0, "bp_in_ready", $sformatf("got %0b want 0", in_ready));
            repeat (3) @(posedge clk);
            #1 ready_force = 1;
         end
      join
      drain();
      check(n_out - base == 4, "bp_delivered", $sformatf("got %0d words want 4", n_out - base));

      // randomized traffic with random backpressure and counter clears
      rand_mode = 1;
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         send(rand_word($urandom_range(0, 3)));
      end
      ready_force = 1;
      rand_mode = 0;
      drain();

      // saturation of the 2-bit counter
      clr_force = 1;
      @(posedge clk); #1 clr_force = 0;
      for (int i = 0; i < 5; i++) send(rand_word(1));
      drain();
      check(s_corrected_cnt == 3, "small_saturate", $sformatf("got %0d want 3", s_corrected_cnt));
      check(corrected_cnt == 5, "big_count5", $sformatf("got %0d want 5", corrected_cnt));

      // clear coinciding with a transfer wins
      ready_force = 0;
      send(rand_word(1));
      wait_out_valid("clr_wait");
      @(posedge clk); #1;
      ready_force = 1; clr_force = 1;
      @(posedge clk); #1;
      ready_force = 0; clr_force = 0;
      check(corrected_cnt == 0 && s_corrected_cnt == 0, "clr_priority",
            $sformatf("got %0d/%0d want 0/0", corrected_cnt, s_corrected_cnt));
      check(exp_q.size() == 0, "clr_transfer", $sformatf("%0d words pending want 0", exp_q.size()));

      // reset during a stall with two words in flight
      send(rand_word(0));
      send(rand_word(2));
      check(out_valid == 1 && in_ready == 0, "pre_reset_stall",
            $sformatf("got v=%0b rdy=%0b want 1/0", out_valid, in_ready));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ready_force = 1;
      check(out_valid == 0 && in_ready == 1, "post_reset_handshake",
            $sformatf("got v=%0b rdy=%0b want 0/1", out_valid, in_ready));
      check(corrected_cnt == 0 && uncorrectable_cnt == 0 && s_uncorrectable_cnt == 0, "post_reset_counters",
            $sformatf("got %0d/%0d/%0d want 0", corrected_cnt, uncorrectable_cnt, s_uncorrectable_cnt));
      send(10'h392);
      check(out_valid == 0, "latency_early", $sformatf("got out_valid=%0b one clock after presentation, want 0", out_valid));
      @(posedge clk); #1;
      check(out_valid == 1 && out_data == 5'b10110, "latency_two",
            $sformatf("got v=%0b data=%b want 1/10110", out_valid, out_data));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/secded_stream_decoder.md
Name: secded_stream_decoder

Overview:
- Downstream consumer of the 10-bit SECDED codeword produced by the encoder / error-injection stage.
- Accepts codewords over a valid/ready handshake, computes the 4-bit Hamming syndrome and the overall parity, corrects single-bit errors and flags uncorrectable ones.
- Emits the recovered 5-bit data word, status and error position through a 2-stage stallable pipeline.
- Keeps saturating counters of corrected and uncorrectable words for the board-level display.

Parameters:
- CNT_W, 8, width of each statistics counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_codeword is valid.
- in_ready  output  1  block can accept a codeword this cycle.
- in_codeword  input  10  codeword; bits [8:0] are Hamming positions 1..9, bit [9] is overall even parity.
- out_valid  output  1  output word is valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  5  recovered data {d4,d3,d2,d1,d0}.
- out_status  output  2  0=clean, 1=corrected, 2=uncorrectable; 3 is never driven.
- out_err_pos  output  4  Hamming position corrected (1..9), 10 for parity bit, 0 if clean, raw syndrome if uncorrectable.
- clr_cnt  input  1  synchronous clear of both counters.
- corrected_cnt  output  CNT_W  count of delivered words with status 1.
- uncorrectable_cnt  output  CNT_W  count of delivered words with status 2.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Codeword bit map:
  - cw[0]=p1, cw[1]=p2, cw[2]=d0, cw[3]=p4, cw[4]=d1, cw[5]=d2, cw[6]=d3, cw[7]=p8, cw[8]=d4, cw[9]=P.
- Syndrome:
  - s0 = cw0^cw2^cw4^cw6^cw8
  - s1 = cw1^cw2^cw5^cw6
  - s2 = cw3^cw4^cw5^cw6
  - s3 = cw7^cw8
  - par = XOR of cw[9:0].
- Classification:
  - s=0, par=0: clean, err_pos 0.
  - par=1, s in 1..9: flip cw[s-1]; status 1, err_pos s.
  - par=1, s=0: parity bit only; data untouched, status 1, err_pos 10.
  - par=0, s≠0: double error; status 2, err_pos s, data taken uncorrected.
  - par=1, s in 10..15: invalid syndrome; status 2, err_pos s, data uncorrected.
- Pipeline:
  - Stage 1 registers the codeword, syndrome and par.
  - Stage 2 registers the corrected data, status and err_pos.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - On stall, every pipeline register holds its value.
  - Otherwise both stages advance; bubbles propagate as valid=0.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+2 when unstalled. Throughput is 1 word/cycle.
- Output stability: out_data, out_status and out_err_pos are stable while out_valid=1 and out_ready=0.
- Counters:
  - Increment only on an output transfer (out_valid & out_ready), by status.
  - Saturate at 2^CNT_W-1, no wrap.
  - clr_cnt has priority over an increment in the same cycle.
  - Counters are independent of stall.
- Reset:
  - Clears both stage valids, out_data, out_status, out_err_pos and both counters to 0.
  - Reset mid-stream drops any in-flight words; in_ready is 1 in the first cycle after reset.
- Simultaneous events: in_valid=1 during a stall is not accepted; the upstream stage must hold the word.

Decomposition:
- Package secded_pkg:
  - CW_W=10, DATA_W=5, SYN_W=4.
  - Status encodings ST_CLEAN/ST_CORR/ST_UNCORR.
  - ERR_POS_PARITY=10.
  - Syndrome and extract functions, shared with the encoder stage.
- One natural sub-module: secded_syndrome, a combinational syndrome-plus-parity generator instanced in stage 1.

Test Plan:
- Clean word: in_codeword=10'h3B2 (data 5'b10110), out_ready=1 -> out_data=5'b10110, out_status=0, out_err_pos=0 two cycles later; counters unchanged.
- Single error: 10'h392 (cw[5] flipped) -> out_data=5'b10110, out_status=1, out_err_pos=6; corrected_cnt=1. Same check for 10'h1B2 -> out_status=1, out_err_pos=10.
- Double and invalid syndrome:
  - 10'h393 -> out_status=2, out_err_pos=7.
  - 10'h331 (three flips) -> out_status=2, out_err_pos=11.
  - Result: uncorrectable_cnt=2.
- Backpressure: stream 4 words with out_ready held 0 for 3 cycles -> in_ready=0 after the pipe fills; outputs held steady; all 4 words delivered in order, none lost or duplicated.
- Counter saturation and clear: CNT_W=2, 5 single-error words -> corrected_cnt sticks at 3. Assert clr_cnt together with a transfer -> counter reads 0.
- Reset mid-stream: rst during a stall with 2 words in flight -> next cycle out_valid=0, in_ready=1, counters 0; the next accepted word emerges 2 cycles later.
